// File: rtl/div_bus_frontend_if.sv
// Signal bundle between the byte-wide bus front end, its producer/consumer and the divider.
// The slave modport is the front end's view; master is the environment's view.
interface div_bus_frontend_if;
   logic [7:0]  bus_in;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  bus_out;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        div_err;
   logic [15:0] div_a;
   logic [15:0] div_b;
   logic        div_start;
   logic        div_ready;
   logic        div_done;
   logic [15:0] div_q;
   logic [15:0] div_r;

   modport slave (
      input  bus_in, in_valid, out_ready, div_ready, div_done, div_q, div_r,
      output in_ready, bus_out, out_valid, busy, div_err, div_a, div_b, div_start
   );

   modport master (
      output bus_in, in_valid, out_ready, div_ready, div_done, div_q, div_r,
      input  in_ready, bus_out, out_valid, busy, div_err, div_a, div_b, div_start
   );
endinterface

// File: rtl/div_bus_frontend.sv
// Byte-serial operand collection and result return around a 16-bit signed divider,
// with local handling of divide-by-zero and divider timeout.
module div_bus_frontend #(
   parameter int START_CYCLES = 1,
   parameter int WAIT_TIMEOUT = 127
) (
   input  logic               clk,
   input  logic               rst,
   div_bus_frontend_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_COLLECT  = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_START    = 3'd2,
      ST_RUN      = 3'd3,
      ST_EMIT     = 3'd4
   } state_e;

   localparam logic [2:0] START_LAST = 3'(START_CYCLES - 1);
   localparam logic [6:0] RUN_LAST   = 7'(WAIT_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
   logic [7:0]  bus_out_q, bus_out_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        start_q, start_d;
   logic [2:0]  start_cnt_q, start_cnt_d;
   logic [6:0]  run_cnt_q, run_cnt_d;

   // Result bytes leave as Q low, Q high, R low, R high.
   function automatic logic [7:0] result_byte(input logic [1:0] idx, input logic [15:0] q,
                                              input logic [15:0] r);
      logic [7:0] b;
      case (idx)
         2'd0:    b = q[7:0];
         2'd1:    b = q[15:8];
         2'd2:    b = r[7:0];
         2'd3:    b = r[15:8];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      q_d         = q_q;
      r_d         = r_q;
      bus_out_d   = bus_out_q;
      err_d       = err_q;
      start_cnt_d = start_cnt_q;
      run_cnt_d   = run_cnt_q;

      case (state_q)
         ST_COLLECT: begin
            if (bus.in_valid) begin
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0:    a_d[7:0]  = bus.bus_in;
                  2'd1:    a_d[15:8] = bus.bus_in;
                  2'd2:    b_d[7:0]  = bus.bus_in;
                  2'd3:    b_d[15:8] = bus.bus_in;
                  default: a_d       = a_q;
               endcase
               if (idx_q == 2'd3) begin
                  // A zero divisor never reaches the divider.
                  if ({bus.bus_in, b_q[7:0]} == 16'h0000) begin
                     q_d       = 16'hFFFF;
                     r_d       = a_q;
                     err_d     = 1'b1;
                     bus_out_d = 8'hFF;
                     state_d   = ST_EMIT;
                  end else begin
                     state_d = ST_WAIT_RDY;
                  end
               end else begin
                  state_d = ST_COLLECT;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_WAIT_RDY: begin
            if (bus.div_ready) begin
               start_cnt_d = 3'd0;
               state_d     = ST_START;
            end else begin
               state_d = ST_WAIT_RDY;
            end
         end
         ST_START: begin
            if (start_cnt_q == START_LAST) begin
               run_cnt_d = 7'd0;
               state_d   = ST_RUN;
            end else begin
               start_cnt_d = start_cnt_q + 3'd1;
            end
         end
         ST_RUN: begin
            // A done pulse on the final allowed cycle still beats the timeout.
            if (bus.div_done) begin
               q_d       = bus.div_q;
               r_d       = bus.div_r;
               err_d     = 1'b0;
               bus_out_d = bus.div_q[7:0];
               idx_d     = 2'd0;
               state_d   = ST_EMIT;
            end else if (run_cnt_q == RUN_LAST) begin
               q_d       = 16'hFFFF;
               r_d       = 16'hFFFF;
               err_d     = 1'b1;
               bus_out_d = 8'hFF;
               idx_d     = 2'd0;
               state_d   = ST_EMIT;
            end else begin
               run_cnt_d = run_cnt_q + 7'd1;
            end
         end
         ST_EMIT: begin
            if (bus.out_ready) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  err_d   = 1'b0;
                  state_d = ST_COLLECT;
               end else begin
                  bus_out_d = result_byte(idx_q + 2'd1, q_q, r_q);
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            idx_d   = 2'd0;
            state_d = ST_COLLECT;
         end
      endcase

      out_valid_d = (state_d == ST_EMIT);
      start_d     = (state_d == ST_START);
      busy_d      = (state_d == ST_WAIT_RDY) || (state_d == ST_START) || (state_d == ST_RUN);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_COLLECT;
         idx_q       <= 2'd0;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         q_q         <= 16'h0000;
         r_q         <= 16'h0000;
         bus_out_q   <= 8'h00;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         start_q     <= 1'b0;
         start_cnt_q <= 3'd0;
         run_cnt_q   <= 7'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         q_q         <= q_d;
         r_q         <= r_d;
         bus_out_q   <= bus_out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         start_q     <= start_d;
         start_cnt_q <= start_cnt_d;
         run_cnt_q   <= run_cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_COLLECT);
   assign bus.bus_out   = bus_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.div_err   = err_q;
   assign bus.div_a     = a_q;
   assign bus.div_b     = b_q;
   assign bus.div_start = start_q;

endmodule

// File: tb/tb_div_bus_frontend.sv
// Scoreboard bench for div_bus_frontend with a behavioural divider of programmable latency.
module tb_div_bus_frontend;
   localparam int SC = 2;
   localparam int WT = 127;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_bus_frontend_if bif();

   div_bus_frontend #(.START_CYCLES(SC), .WAIT_TIMEOUT(WT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   logic       exp_err_q[$];

   int  lat_m     = 5;
   bit  rdy_block = 1'b0;
   bit  pending_m = 1'b0;
   int  cnt_m     = 0;
   bit  prev_start = 1'b0;
   logic signed [15:0] ma, mb;

   // Divider model: latches operands when div_start falls, pulses done lat_m cycles into RUN.
   always @(posedge clk) begin
      bif.div_done <= 1'b0;
      if (rst !== 1'b1) begin
         pending_m  = 1'b0;
         prev_start = 1'b0;
         bif.div_ready <= 1'b1;
      end else begin
         if (prev_start && bif.div_start === 1'b0) begin
            ma = bif.div_a;
            mb = bif.div_b;
            pending_m = 1'b1;
            cnt_m = 1;
         end else if (pending_m) begin
            cnt_m++;
         end
         if (pending_m && cnt_m == lat_m) begin
            bif.div_done <= 1'b1;
            bif.div_q    <= ma / mb;
            bif.div_r    <= ma % mb;
            pending_m = 1'b0;
         end
         prev_start = (bif.div_start === 1'b1);
         bif.div_ready <= !pending_m && !rdy_block;
      end
   end

   int start_cyc = 0, start_pulses = 0, run_cyc = 0;
   bit seen_start = 1'b0;
   bit prev_mon   = 1'b0;

   // Cycle monitor for start width, start pulse count and cycles spent in RUN.
   always @(negedge clk) begin
      if (bif.div_start === 1'b1) begin
         start_cyc++;
         if (!prev_mon) start_pulses++;
         seen_start = 1'b1;
      end else if (bif.busy === 1'b1 && seen_start) begin
         run_cyc++;
      end else if (bif.busy !== 1'b1) begin
         seen_start = 1'b0;
      end
      prev_mon = (bif.div_start === 1'b1);
   end

   task automatic push_result(input logic [15:0] q, input logic [15:0] r, input logic err);
      exp_q.push_back(q[7:0]);
      exp_q.push_back(q[15:8]);
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
      for (int k = 0; k < 4; k++) exp_err_q.push_back(err);
   endtask

   task automatic push_div(input logic [15:0] a, input logic [15:0] b);
      logic signed [15:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 16'h0000) push_result(16'hFFFF, a, 1'b1);
      else               push_result(sa / sb, sa % sb, 1'b0);
   endtask

   task automatic send_bytes(input logic [15:0] a, input logic [15:0] b);
      logic [7:0] bytes[4];
      int n;
      bytes[0] = a[7:0]; bytes[1] = a[15:8]; bytes[2] = b[7:0]; bytes[3] = b[15:8];
      for (int k = 0; k < 4; k++) begin
         bif.bus_in   = bytes[k];
         bif.in_valid = 1'b1;
         n = 0;
         while (bif.in_ready !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
         checks++;
         if (bif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", bif.in_ready);
         end
         @(posedge clk); #1;
      end
      bif.in_valid = 1'b0;
   endtask

   task automatic recv_op(input string name, input bit stall);
      logic [7:0] eb;
      logic       ee;
      int n;
      bif.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (bif.out_valid !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
         checks++;
         if (bif.out_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_valid: out_valid=%b queued=%0d required 1", name, bif.out_valid, exp_q.size());
            exp_q.delete();
            exp_err_q.delete();
            bif.out_ready = 1'b0;
            return;
         end
         eb = exp_q.pop_front();
         ee = exp_err_q.pop_front();
         checks++;
         if (bif.bus_out !== eb) begin
            failures++;
            $display("FAIL %s_byte%0d: got %h required %h", name, k, bif.bus_out, eb);
         end
         checks++;
         if (bif.div_err !== ee || bif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_err%0d: div_err=%b in_ready=%b required %b 0", name, k, bif.div_err, bif.in_ready, ee);
         end
         @(posedge clk); #1;
         if (stall && k == 1) begin
            bif.out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               checks++;
               if (bif.out_valid !== 1'b1 || bif.bus_out !== exp_q[0] || bif.in_ready !== 1'b0) begin
                  failures++;
                  $display("FAIL %s_hold%0d: valid=%b bus_out=%h in_ready=%b required 1 %h 0", name, s, bif.out_valid, bif.bus_out, bif.in_ready, exp_q[0]);
               end
               @(posedge clk); #1;
            end
            bif.out_ready = 1'b1;
         end
      end
      bif.out_ready = 1'b0;
      checks++;
      if (bif.out_valid !== 1'b0 || bif.div_err !== 1'b0 || bif.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_done: valid=%b err=%b in_ready=%b required 0 0 1", name, bif.out_valid, bif.div_err, bif.in_ready);
      end
   endtask

   task automatic do_reset(input string name);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bif.in_ready, bif.out_valid, bif.busy, bif.div_err, bif.div_start} !== 5'b10000 ||
          bif.div_a !== 16'h0000 || bif.div_b !== 16'h0000 || bif.bus_out !== 8'h00) begin
         failures++;
         $display("FAIL %s: rdy/vld/busy/err/start=%b a=%h b=%h out=%h required 10000 0000 0000 00", name,
                  {bif.in_ready, bif.out_valid, bif.busy, bif.div_err, bif.div_start}, bif.div_a, bif.div_b, bif.bus_out);
      end
      rst = 1'b1;
   endtask

   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b);
      int p0;
      p0 = start_pulses;
      push_div(a, b);
      send_bytes(a, b);
      recv_op(name, 1'b0);
      checks++;
      if (start_pulses - p0 !== ((b == 16'h0000) ? 0 : 1)) begin
         failures++;
         $display("FAIL %s_pulses: got %0d required %0d", name, start_pulses - p0, (b == 16'h0000) ? 0 : 1);
      end
   endtask

   task automatic test_reset;
      bif.in_valid = 1'b0; bif.bus_in = 8'h00; bif.out_ready = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_reset("reset_state");
   endtask

   task automatic test_basic;
      int c0;
      c0 = start_cyc;
      run_op("a100_b7", 16'd100, 16'd7);
      checks++;
      if (start_cyc - c0 !== SC) begin
         failures++;
         $display("FAIL start_width: got %0d required %0d", start_cyc - c0, SC);
      end
   endtask

   task automatic test_signed;
      run_op("am100_b7", 16'hFF9C, 16'd7);
      run_op("a100_bm7", 16'd100, 16'hFFF9);
      run_op("amin_b3", 16'h8000, 16'd3);
   endtask

   task automatic test_zero_div;
      int p0;
      p0 = start_pulses;
      push_div(16'h1234, 16'h0000);
      send_bytes(16'h1234, 16'h0000);
      checks++;
      if (bif.out_valid !== 1'b1 || bif.div_err !== 1'b1) begin
         failures++;
         $display("FAIL zdiv_latency: valid=%b err=%b required 1 1", bif.out_valid, bif.div_err);
      end
      recv_op("zdiv", 1'b0);
      checks++;
      if (start_pulses != p0) begin
         failures++;
         $display("FAIL zdiv_start: pulses=%0d required 0", start_pulses - p0);
      end
      run_op("after_zdiv", 16'd1000, 16'hFFFD);
   endtask

   task automatic test_backpressure;
      push_div(16'd12345, 16'd100);
      send_bytes(16'd12345, 16'd100);
      recv_op("bp", 1'b1);
   endtask

   task automatic test_wait_ready;
      rdy_block = 1'b1;
      push_div(16'd500, 16'd9);
      send_bytes(16'd500, 16'd9);
      repeat (6) begin
         @(posedge clk); #1;
         checks++;
         if (bif.busy !== 1'b1 || bif.div_start !== 1'b0 || bif.div_a !== 16'd500 || bif.div_b !== 16'd9) begin
            failures++;
            $display("FAIL wait_rdy: busy=%b start=%b a=%h b=%h required 1 0 01f4 0009", bif.busy, bif.div_start, bif.div_a, bif.div_b);
         end
      end
      rdy_block = 1'b0;
      recv_op("wait_rdy", 1'b0);
   endtask

   task automatic test_timeout;
      int r0;
      lat_m = 100000;
      r0 = run_cyc;
      push_result(16'hFFFF, 16'hFFFF, 1'b1);
      send_bytes(16'd5, 16'd1);
      recv_op("timeout", 1'b0);
      checks++;
      if (run_cyc - r0 !== WT) begin
         failures++;
         $display("FAIL timeout_cycles: got %0d required %0d", run_cyc - r0, WT);
      end
      do_reset("timeout_reset");
      lat_m = 5;
   endtask

   task automatic test_boundary;
      int r0;
      lat_m = WT - 1;
      r0 = run_cyc;
      run_op("done_at_limit", 16'd77, 16'd6);
      checks++;
      if (run_cyc - r0 !== WT) begin
         failures++;
         $display("FAIL limit_cycles: got %0d required %0d", run_cyc - r0, WT);
      end
      lat_m = WT;
      push_result(16'hFFFF, 16'hFFFF, 1'b1);
      send_bytes(16'd77, 16'd6);
      recv_op("done_after_limit", 1'b0);
      lat_m = 5;
      run_op("after_limit", 16'hFC18, 16'd7);
   endtask

   task automatic test_reset_mid;
      int n;
      bif.bus_in = 8'hAA; bif.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bif.in_valid = 1'b0;
      do_reset("reset_collect");
      run_op("fresh_after_collect", 16'd300, 16'hFFF9);
      lat_m = 20;
      send_bytes(16'd77, 16'd5);
      n = 0;
      while (!(seen_start && bif.busy === 1'b1 && bif.div_start === 1'b0) && n < 400) begin
         @(posedge clk); #1; n++;
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bif.busy !== 1'b1) begin
         failures++;
         $display("FAIL reach_run: busy=%b required 1", bif.busy);
      end
      do_reset("reset_run");
      repeat (25) @(posedge clk);
      #1;
      checks++;
      if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL stale_done: valid=%b in_ready=%b required 0 1", bif.out_valid, bif.in_ready);
      end
      lat_m = 5;
      run_op("fresh_after_run", 16'hFFB3, 16'd5);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_zero_div();
      test_backpressure();
      test_wait_ready();
      test_timeout();
      test_boundary();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
